multi_timer: RTL and testbench

- Memory-mapped, parametrised multi-channel timer on the CPU bridge. Generalises the single-channel timer device.
- Adds NUM_CH independent down-counters, a per-channel clock prescaler, an auto-reload mode and a hold mode.
- Adds sticky per-channel interrupt-pending flags with write-1-to-clear, a per-channel IRQ vector and an OR-ed IRQ line to the CP0 interrupt input.

---
 rtl/multi_timer_pkg.sv | 30 +++
 rtl/multi_timer_channel.sv | 152 +++++++++++++++
 rtl/multi_timer.sv | 78 +++++++
 tb/tb_multi_timer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_timer_pkg.sv
// Shared types and register-map constants for the multi-channel timer.
package multi_timer_pkg;

    // Per-channel control state.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        COUNTING = 2'd2,
        HOLD     = 2'd3
    } state_e;

    // CTRL.Mode encodings; the fourth code (2'b11) behaves as one-shot.
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;
    localparam logic [1:0] MODE_HOLD    = 2'b10;

    // Register offsets inside one channel window, plus the shared STATUS word.
    localparam logic [3:0]  OFF_CTRL   = 4'h0;
    localparam logic [3:0]  OFF_PRESET = 4'h4;
    localparam logic [3:0]  OFF_COUNT  = 4'h8;
    localparam logic [31:0] OFF_STATUS = 32'h40;
    localparam int          CH_STRIDE  = 16;

    // CTRL bit positions.
    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_IM_BIT   = 3;
    localparam int CTRL_DIV_LSB  = 4;

endpackage

// File: rtl/multi_timer_channel.sv
// One timer channel: CTRL/PRESET registers, prescaler, down-counter,
// control FSM and the sticky pending flag.
module timer_channel
    import multi_timer_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ctrl_we_i,
    input  logic        preset_we_i,
    input  logic        w1c_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ctrl_rd_o,
    output logic [31:0] preset_rd_o,
    output logic [31:0] count_rd_o,
    output logic        pending_o,
    output logic        irq_o
);

    state_e             state_q, state_d;
    logic               en_q, en_d;
    logic [1:0]         mode_q, mode_d;
    logic               im_q, im_d;
    logic [PRESC_W-1:0] div_q, div_d;
    logic [PRESC_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0]   preset_q, preset_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               pending_q, pending_d;
    logic               tick;

    assign tick = (pcnt_q == div_q);

    // Next-state logic: FSM, prescaler, counter and pending; register writes last so they win.
    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        en_d      = en_q;
        mode_d    = mode_q;
        im_d      = im_q;
        div_d     = div_q;
        pcnt_d    = pcnt_q;
        preset_d  = preset_q;
        count_d   = count_q;
        pending_d = pending_q;

        if (preset_we_i) begin
            preset_d = wdata_i[CNT_W-1:0];
        end
        // Clear first; an expiry below in the same cycle sets it again.
        if (w1c_i) begin
            pending_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (en_q) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                count_d = preset_q;
                pcnt_d  = '0;
                state_d = COUNTING;
            end
            COUNTING: begin
                if (!en_q) begin
                    state_d = IDLE;
                end else if (tick) begin
                    pcnt_d = '0;
                    if (count_q > CNT_W'(1)) begin
                        count_d = count_q - CNT_W'(1);
                    end else begin
                        pending_d = 1'b1;
                        case (mode_q)
                            MODE_RELOAD: begin
                                // Uses the registered PRESET, so a same-cycle PRESET write
                                // only affects the following reload.
                                count_d = preset_q;
                            end
                            MODE_HOLD: begin
                                count_d = '0;
                                state_d = HOLD;
                            end
                            MODE_ONESHOT, 2'b11: begin
                                count_d = '0;
                                en_d    = 1'b0;
                                state_d = IDLE;
                            end
                        endcase
                    end
                end else begin
                    pcnt_d = pcnt_q + PRESC_W'(1);
                end
            end
            HOLD: begin
                // Released once software has cleared the pending flag.
                if (!pending_q || !en_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A CTRL write restarts the channel and discards any same-cycle tick.
        // IDLE is passed through within this edge, so an enabling write loads at the next edge.
        if (ctrl_we_i) begin
            en_d      = wdata_i[CTRL_EN_BIT];
            mode_d    = wdata_i[CTRL_MODE_LSB +: 2];
            im_d      = wdata_i[CTRL_IM_BIT];
            div_d     = wdata_i[CTRL_DIV_LSB +: PRESC_W];
            pcnt_d    = '0;
            pending_d = 1'b0;
            count_d   = count_q;
            state_d   = wdata_i[CTRL_EN_BIT] ? LOAD : IDLE;
        end
    end

    // State and register flops, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            en_q      <= 1'b0;
            mode_q    <= 2'b00;
            im_q      <= 1'b0;
            div_q     <= '0;
            pcnt_q    <= '0;
            preset_q  <= '0;
            count_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values computed above.
            state_q   <= state_d;
            en_q      <= en_d;
            mode_q    <= mode_d;
            im_q      <= im_d;
            div_q     <= div_d;
            pcnt_q    <= pcnt_d;
            preset_q  <= preset_d;
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end

    assign ctrl_rd_o   = 32'({div_q, im_q, mode_q, en_q});
    assign preset_rd_o = 32'(preset_q);
    assign count_rd_o  = 32'(count_q);
    assign pending_o   = pending_q;
    assign irq_o       = pending_q & im_q;

endmodule

// File: rtl/multi_timer.sv
// Memory-mapped multi-channel timer: address decode, read mux,
// STATUS write-1-to-clear fan-out and the combined interrupt line.
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter int          NUM_CH    = 2,
    parameter int          CNT_W     = 32,
    parameter int          PRESC_W   = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_7f00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       Addr,
    input  logic              WE,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic              IRQ,
    output logic [NUM_CH-1:0] IRQ_vec
);

    logic [31:0]       off;
    logic              ch_hit;
    logic              status_hit;
    logic [1:0]        ch_idx;
    logic [NUM_CH-1:0] pending;
    logic [31:0]       ctrl_rd   [NUM_CH];
    logic [31:0]       preset_rd [NUM_CH];
    logic [31:0]       count_rd  [NUM_CH];

    assign off        = Addr - BASE_ADDR;
    assign ch_hit     = (off < 32'(4 * CH_STRIDE)) && (off[1:0] == 2'b00);
    assign status_hit = (off == OFF_STATUS);
    assign ch_idx     = off[5:4];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic sel_we;
        assign sel_we = WE && ch_hit && (ch_idx == 2'(g));

        timer_channel #(
            .CNT_W   (CNT_W),
            .PRESC_W (PRESC_W)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .ctrl_we_i   (sel_we && (off[3:0] == OFF_CTRL)),
            .preset_we_i (sel_we && (off[3:0] == OFF_PRESET)),
            .w1c_i       (WE && status_hit && DataIn[g]),
            .wdata_i     (DataIn),
            .ctrl_rd_o   (ctrl_rd[g]),
            .preset_rd_o (preset_rd[g]),
            .count_rd_o  (count_rd[g]),
            .pending_o   (pending[g]),
            .irq_o       (IRQ_vec[g])
        );
    end

    // Read mux; absent channels and unmapped offsets return zero.
    always_comb begin
        DataOut = '0;
        if (status_hit) begin
            DataOut = 32'(pending);
        end else if (ch_hit) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_idx == 2'(i)) begin
                    case (off[3:0])
                        OFF_CTRL:   DataOut = ctrl_rd[i];
                        OFF_PRESET: DataOut = preset_rd[i];
                        OFF_COUNT:  DataOut = count_rd[i];
                        default:    DataOut = '0;
                    endcase
                end
            end
        end
    end

    assign IRQ = |IRQ_vec;

endmodule

// File: tb/tb_multi_timer.sv
// Bench for multi_timer: directed scenarios plus random traffic, all checked
// against a per-channel behavioural model of the timer.
module tb_multi_timer;

    localparam int          NCH  = 2;
    localparam logic [31:0] BASE = 32'h0000_7f00;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Addr, DataIn, DataOut, DataOut1;
    logic        WE;
    logic        IRQ, IRQ1;
    logic [NCH-1:0] IRQ_vec;
    logic [0:0]  IRQ_vec1;

    always #5 clk = ~clk;

    multi_timer #(.NUM_CH(NCH), .CNT_W(32), .PRESC_W(8), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .DataIn(DataIn),
        .DataOut(DataOut), .IRQ(IRQ), .IRQ_vec(IRQ_vec)
    );

    // Single-channel instance sharing the bus; its channel 0 sees the same traffic.
    multi_timer #(.NUM_CH(1), .CNT_W(32), .PRESC_W(8), .BASE_ADDR(BASE)) dut1 (
        .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .DataIn(DataIn),
        .DataOut(DataOut1), .IRQ(IRQ1), .IRQ_vec(IRQ_vec1)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural channel: register fields plus what the channel is doing next.
    typedef struct {
        bit          en;
        int          mode;
        bit          im;
        int          div;
        int unsigned preset;
        int unsigned count;
        int          pcnt;
        bit          pend;
        bit          load_next;
        bit          running;
        bit          frozen;
    } chm_t;

    chm_t m[NCH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) m[c] = '{default: 0};
    endfunction

    // Advance the model by one clock edge using the bus values present before it.
    function automatic void model_step(input logic [31:0] a, input logic we, input logic [31:0] d);
        int unsigned off = a - BASE;
        for (int c = 0; c < NCH; c++) begin
            chm_t o = m[c];
            chm_t n = m[c];
            bit wr_ctrl = we && (off == 16 * c);
            bit wr_pre  = we && (off == 16 * c + 4);
            bit clr     = we && (off == 64) && d[c];
            if (wr_pre) n.preset = d;
            if (clr)    n.pend   = 1'b0;
            if (o.load_next) begin
                n.count = o.preset; n.pcnt = 0; n.load_next = 0; n.running = 1;
            end else if (o.running) begin
                if (!o.en) n.running = 0;
                else if (o.pcnt == o.div) begin
                    n.pcnt = 0;
                    if (o.count > 1) n.count = o.count - 1;
                    else begin
                        n.pend = 1'b1;
                        if (o.mode == 1) n.count = o.preset;
                        else if (o.mode == 2) begin n.count = 0; n.running = 0; n.frozen = 1; end
                        else begin n.count = 0; n.en = 0; n.running = 0; end
                    end
                end else n.pcnt = o.pcnt + 1;
            end else if (o.frozen) begin
                if (!o.pend || !o.en) n.frozen = 0;
            end else if (o.en) n.load_next = 1;
            if (wr_ctrl) begin
                n.en = d[0]; n.mode = int'(d[2:1]); n.im = d[3]; n.div = int'(d[11:4]);
                n.pcnt = 0; n.pend = 0; n.count = o.count;
                n.running = 0; n.frozen = 0; n.load_next = d[0];
            end
            m[c] = n;
        end
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        int unsigned off = a - BASE;
        logic [31:0] r = '0;
        if (off == 64) begin
            for (int c = 0; c < NCH; c++) r[c] = m[c].pend;
        end else if (off < 64 && off % 4 == 0 && off / 16 < NCH) begin
            int c = int'(off / 16);
            case (off % 16)
                0: r = 32'(m[c].en) | (32'(m[c].mode) << 1) | (32'(m[c].im) << 3) | (32'(m[c].div) << 4);
                4: r = m[c].preset;
                8: r = m[c].count;
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        Addr = a;
        #1;
        check(tag, DataOut, exp);
    endtask

    task automatic compare_all();
        bit any = 0;
        for (int c = 0; c < NCH; c++) begin
            check($sformatf("irq_vec%0d", c), 32'(IRQ_vec[c]), 32'(m[c].pend & m[c].im));
            any |= m[c].pend & m[c].im;
        end
        check("irq", 32'(IRQ), 32'(any));
        check("n1_irq_vec0", 32'(IRQ_vec1[0]), 32'(m[0].pend & m[0].im));
        read_chk("status", BASE + 32'h40, exp_read(BASE + 32'h40));
        for (int c = 0; c < NCH; c++)
            read_chk($sformatf("count%0d", c), BASE + 32'(16 * c + 8), exp_read(BASE + 32'(16 * c + 8)));
    endtask

    task automatic tick_clk();
        model_step(Addr, WE, DataIn);
        @(posedge clk);
        #1;
        WE = 1'b0;
        compare_all();
    endtask

    task automatic write_reg(input logic [31:0] a, input logic [31:0] d);
        Addr = a; DataIn = d; WE = 1'b1;
        tick_clk();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, k;
        logic [31:0] d;
        int unsigned seq[8] = '{2, 2, 2, 2, 1, 1, 1, 1};

        reset = 1'b1; WE = 1'b0; Addr = BASE; DataIn = '0;
        model_reset();
        #3;
        check("rst_irq", 32'(IRQ), 32'h0);
        check("rst_irq_vec", 32'(IRQ_vec), 32'h0);
        read_chk("rst_ctrl0", BASE, 32'h0);
        read_chk("rst_status", BASE + 32'h40, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // One-shot on channel 0: PRESET=5, DIV=0, IRQ exactly 6 edges after the write.
        write_reg(BASE + 32'h4, 32'd5);
        write_reg(BASE + 32'h0, 32'h9);
        first = -1;
        for (int i = 1; i <= 12; i++) begin
            tick_clk();
            if (IRQ && first < 0) first = i;
        end
        check("oneshot_latency", 32'(first), 32'd6);
        check("oneshot_irq_sticky", 32'(IRQ), 32'h1);
        read_chk("oneshot_ctrl", BASE, 32'h8);
        read_chk("oneshot_count", BASE + 32'h8, 32'h0);
        write_reg(BASE + 32'h40, 32'h1);
        check("oneshot_w1c", 32'(IRQ), 32'h0);

        // Auto-reload on channel 1: PRESET=3, clear after each rise, period 3.
        write_reg(BASE + 32'h14, 32'd3);
        write_reg(BASE + 32'h10, 32'h0B);
        for (int r = 0; r < 3; r++) begin
            k = 0;
            while (!IRQ_vec[1] && k < 20) begin
                tick_clk();
                k++;
            end
            check($sformatf("reload_gap%0d", r), 32'(k), (r == 0) ? 32'd4 : 32'd2);
            check("reload_ch0_quiet", 32'(IRQ_vec[0]), 32'h0);
            write_reg(BASE + 32'h40, 32'h2);
        end
        write_reg(BASE + 32'h10, 32'h0);

        // Prescaler: PRESET=2, DIV=3, one-shot, IM=0.
        write_reg(BASE + 32'h4, 32'd2);
        write_reg(BASE + 32'h0, 32'h31);
        for (int i = 0; i < 8; i++) begin
            tick_clk();
            read_chk($sformatf("presc_seq%0d", i), BASE + 32'h8, seq[i]);
        end
        read_chk("presc_not_yet", BASE + 32'h40, 32'h0);
        tick_clk();
        read_chk("presc_expired", BASE + 32'h40, 32'h1);
        write_reg(BASE + 32'h40, 32'h1);

        // Hold mode with IM=0: pending visible in STATUS, IRQ stays low, reloads after clear.
        write_reg(BASE + 32'h4, 32'd1);
        write_reg(BASE + 32'h0, 32'h5);
        for (int i = 0; i < 4; i++) tick_clk();
        read_chk("hold_status", BASE + 32'h40, 32'h1);
        check("hold_irq_masked", 32'(IRQ), 32'h0);
        write_reg(BASE + 32'h40, 32'h1);
        read_chk("hold_cleared", BASE + 32'h40, 32'h0);
        first = -1;
        for (int i = 1; i <= 8; i++) begin
            tick_clk();
            Addr = BASE + 32'h40;
            #1;
            if (DataOut[0] && first < 0) first = i;
        end
        check("hold_relaunch", 32'(first > 0), 32'h1);
        write_reg(BASE + 32'h0, 32'h0);
        write_reg(BASE + 32'h40, 32'h1);

        // W1C landing on the expiry edge: set wins.
        write_reg(BASE + 32'h4, 32'd3);
        write_reg(BASE + 32'h0, 32'h9);
        for (int i = 0; i < 3; i++) tick_clk();
        write_reg(BASE + 32'h40, 32'h1);
        read_chk("w1c_collide_status", BASE + 32'h40, 32'h1);
        check("w1c_collide_irq", 32'(IRQ), 32'h1);
        write_reg(BASE + 32'h40, 32'h1);

        // CTRL write on a tick edge: no decrement, then reload through LOAD.
        write_reg(BASE + 32'h4, 32'd5);
        write_reg(BASE + 32'h0, 32'h0B);
        tick_clk();
        tick_clk();
        write_reg(BASE + 32'h0, 32'h0B);
        read_chk("ctrl_tick_hold", BASE + 32'h8, 32'd4);
        tick_clk();
        read_chk("ctrl_tick_reload", BASE + 32'h8, 32'd5);
        write_reg(BASE + 32'h0, 32'h0);

        // PRESET rewritten mid-count: current count unaffected, next reload uses 7.
        write_reg(BASE + 32'h14, 32'd3);
        write_reg(BASE + 32'h10, 32'h0B);
        tick_clk();
        tick_clk();
        write_reg(BASE + 32'h14, 32'd7);
        read_chk("preset_mid_count", BASE + 32'h18, 32'd1);
        tick_clk();
        read_chk("preset_mid_reload", BASE + 32'h18, 32'd7);
        write_reg(BASE + 32'h10, 32'h0);
        write_reg(BASE + 32'h40, 32'h3);

        // Random traffic against the model.
        for (int it = 0; it < 400; it++) begin
            int op = int'($urandom_range(0, 9));
            int ch = int'($urandom_range(0, NCH - 1));
            if (op <= 1) begin
                d = $urandom;
                d[11:4] = 8'($urandom_range(0, 3));
                if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
                write_reg(BASE + 32'(16 * ch), d);
            end else if (op == 2) begin
                d = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 6));
                write_reg(BASE + 32'(16 * ch + 4), d);
            end else if (op == 3) begin
                write_reg(BASE + 32'h40, $urandom);
            end else if (op == 4) begin
                write_reg(BASE + 32'(4 * $urandom_range(0, 20)), $urandom);
            end else begin
                tick_clk();
            end
            d = BASE + 32'(4 * $urandom_range(0, 20));
            read_chk("rand_read", d, exp_read(d));
        end

        // Unmapped offsets and absent channel on the single-channel instance.
        write_reg(BASE + 32'h10, 32'h8);
        read_chk("unmapped_3c", BASE + 32'h3C, 32'h0);
        Addr = BASE + 32'h10;
        #1;
        check("n1_absent_ch1", DataOut1, 32'h0);
        check("ch1_ctrl_present", DataOut, 32'h8);
        write_reg(BASE + 32'h8, 32'h55);

        // Asynchronous reset between edges while counting with IRQ high.
        write_reg(BASE + 32'h4, 32'd3);
        write_reg(BASE + 32'h0, 32'h0B);
        for (int i = 0; i < 6; i++) tick_clk();
        check("pre_reset_irq", 32'(IRQ), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_irq", 32'(IRQ), 32'h0);
        read_chk("async_rst_count0", BASE + 32'h8, 32'h0);
        read_chk("async_rst_ctrl0", BASE, 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick_clk();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
